fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Sequencer between the core's FP issue stage and the FPU arithmetic datapath. It accepts one FP operation at a time and classifies it by op code:
- single pass through the pipelined datapath;
- two passes, with operand mux feedback (fused ops);
- iterative divide/sqrt unit.

It drives the operand-register enable, the operand input select and the iterative-unit start/abort. It returns a one-cycle result-valid with an error flag, and supports pipeline flush and a timeout watchdog on the iterative unit.

Parameters:
PIPE_LAT, 3, datapath pass latency in cycles (>=1)
TIMEOUT, 64, max ITER cycles before abort (>=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and output reset values
req_valid  input  1  core presents an op
req_op  input  5  FP op code
req_ready  output  1  controller can accept an op this cycle
flush  input  1  kill in-flight op
reg_AB_en  output  1  load operand registers A/B
in_sel  output  1  operand mux: 1 = core operands, 0 = datapath feedback
iter_start  output  1  one-cycle start pulse to div/sqrt unit
iter_done  input  1  div/sqrt unit result ready
iter_abort  output  1  one-cycle abort to div/sqrt unit
res_en  output  1  load FPU result register
res_valid  output  1  one-cycle result-valid to core
res_err  output  1  qualifies res_valid: 1 = timeout, result invalid
busy  output  1  state != IDLE

Behaviour:
- Op classes:
  - ITER: req_op = 5'b00100 or 5'b01011.
  - TWO_PASS: req_op = 5'b0001? .
  - SINGLE: all other op codes.
- States: IDLE, PASS1, PASS2, ITER, DONE. Down-counter cnt of width clog2(max(PIPE_LAT, TIMEOUT)+1). Class register cls captured on accept.
- Reset values: state = IDLE, cnt = 0, cls = SINGLE, in_sel = 1. All other outputs 0, except req_ready = 1 when flush = 0.
- req_ready = (state == IDLE) & !flush. Accept = req_valid & req_ready. reg_AB_en = accept (combinational).
- in_sel = 0 only in PASS2; 1 in all other states.
- IDLE, on accept:
  - SINGLE/TWO_PASS -> PASS1, cnt = PIPE_LAT-1.
  - ITER -> ITER, cnt = TIMEOUT-1.
- PASS1: cnt decrements each cycle. At cnt == 0:
  - SINGLE: res_en = 1, -> DONE.
  - TWO_PASS: -> PASS2, cnt = PIPE_LAT-1.
- PASS2: at cnt == 0, res_en = 1, -> DONE.
- ITER:
  - iter_start = 1 on the first ITER cycle only (registered flag set on accept).
  - iter_done is sampled every ITER cycle, including the first. On iter_done: res_en = 1, -> DONE, res_err cleared.
  - Otherwise, if cnt == 0: iter_abort = 1, -> DONE with error flag set. Otherwise cnt decrements.
  - iter_done and the timeout in the same cycle: done wins, no abort.
- DONE: res_valid = 1 and res_err = error flag for exactly one cycle, then -> IDLE. No back-pressure.
- Latency from the accept cycle (cycle 0):
  - SINGLE: res_valid at cycle PIPE_LAT+1.
  - TWO_PASS: res_valid at cycle 2*PIPE_LAT+1.
  - ITER: res_valid one cycle after iter_done; at cycle TIMEOUT+1 on timeout.
- Back-to-back: the earliest next accept is the cycle after DONE, since DONE is followed by IDLE.
- flush has highest priority:
  - In any state, next state = IDLE and cnt = 0.
  - While flush = 1: res_en = 0, res_valid = 0, req_ready = 0.
  - If state == ITER: iter_abort = 1 that cycle, and iter_start is suppressed.
- Reset mid-operation: immediate IDLE with no iter_abort. The div/sqrt unit shares the reset.
- iter_done outside ITER is ignored.

Test Plan:
- SINGLE add (op 00000), PIPE_LAT=3, accept at cycle 0 -> reg_AB_en = 1 at cycle 0; res_en at cycle 3; res_valid = 1, res_err = 0 at cycle 4; req_ready = 1 at cycle 5.
- TWO_PASS op 00011 -> in_sel = 1 in cycles 1-3; in_sel = 0 in cycles 4-6; res_en at cycle 6; res_valid at cycle 7.
- ITER op 00100, iter_done at cycle 10 -> iter_start pulse at cycle 1 only; res_en at cycle 10; res_valid at cycle 11 with res_err = 0.
- ITER op 01011, iter_done never asserted, TIMEOUT=64 -> iter_abort at cycle 64; res_valid = 1 and res_err = 1 at cycle 65.
- Flush at cycle 5 of an ITER op -> iter_abort = 1 at cycle 5; state IDLE at cycle 6; no res_valid. Flush with req_valid in IDLE -> reg_AB_en = 0, no accept.
- Reset asserted in PASS2 -> outputs at reset values immediately (busy = 0, in_sel = 1). After deassert, a new SINGLE op completes with standard latency.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// FP issue sequencer: steps one op through a single datapath pass, two fused passes,
// or the iterative div/sqrt unit, with flush and a watchdog on the iterative unit.
module fpu_issue_ctrl #(
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [4:0] req_op,
  output logic       req_ready,
  input  logic       flush,
  output logic       reg_AB_en,
  output logic       in_sel,
  output logic       iter_start,
  input  logic       iter_done,
  output logic       iter_abort,
  output logic       res_en,
  output logic       res_valid,
  output logic       res_err,
  output logic       busy
);

  localparam int unsigned CntMax = (PIPE_LAT > TIMEOUT) ? PIPE_LAT : TIMEOUT;
  localparam int unsigned CW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StPass1, StPass2, StIter, StDone} state_e;
  typedef enum logic [1:0] {ClsSingle, ClsTwoPass, ClsIter} cls_e;

  state_e        state_q;
  cls_e          cls_q;
  cls_e          req_cls;
  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          start_q;
  logic          accept;
  logic          cnt_zero;

  always_comb begin
    req_cls = ClsSingle;
    if (req_op == 5'b00100 || req_op == 5'b01011) begin
      req_cls = ClsIter;
    end else if (req_op[4:1] == 4'b0001) begin
      req_cls = ClsTwoPass;
    end
  end

  assign cnt_zero   = (cnt_q == '0);
  assign req_ready  = (state_q == StIdle) && !flush;
  assign accept     = req_valid && req_ready;
  assign reg_AB_en  = accept;
  assign in_sel     = (state_q != StPass2);
  assign busy       = (state_q != StIdle);
  assign res_valid  = (state_q == StDone) && !flush;
  assign res_err    = res_valid && err_q;
  assign iter_start = (state_q == StIter) && start_q && !flush;
  // Flush inside ITER always aborts, even if the unit finishes that same cycle.
  assign iter_abort = (state_q == StIter) && (flush || (!iter_done && cnt_zero));
  assign res_en     = !flush &&
                      (((state_q == StPass1) && cnt_zero && (cls_q == ClsSingle)) ||
                       ((state_q == StPass2) && cnt_zero) ||
                       ((state_q == StIter) && iter_done));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cls_q   <= ClsSingle;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cls_q <= req_cls;
            err_q <= 1'b0;
            if (req_cls == ClsIter) begin
              state_q <= StIter;
              cnt_q   <= CW'(TIMEOUT - 1);
              start_q <= 1'b1;
            end else begin
              state_q <= StPass1;
              cnt_q   <= CW'(PIPE_LAT - 1);
            end
          end
        end
        StPass1: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (cls_q == ClsTwoPass) begin
            state_q <= StPass2;
            cnt_q   <= CW'(PIPE_LAT - 1);
          end else begin
            state_q <= StDone;
          end
        end
        StPass2: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= StDone;
          end
        end
        StIter: begin
          start_q <= 1'b0;
          if (iter_done) begin
            state_q <= StDone;
            err_q   <= 1'b0;
          end else if (cnt_zero) begin
            state_q <= StDone;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: random op stream against a timing model built from op classes;
// res_valid is scoreboarded, the other strobes are compared against a per-cycle expectation map.
module tb_fpu_issue_ctrl;

  localparam int P = 3;
  localparam int T = 64;

  // Bit positions in the per-cycle expectation word.
  localparam int BAben  = 0;
  localparam int BStart = 1;
  localparam int BAbort = 2;
  localparam int BResEn = 3;
  localparam int BNinS  = 4;
  localparam int BBusy  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [4:0] req_op = 5'd0;
  logic       flush = 1'b0;
  logic       iter_done = 1'b0;
  logic       req_ready, reg_AB_en, in_sel, iter_start, iter_abort;
  logic       res_en, res_valid, res_err, busy;

  fpu_issue_ctrl #(.PIPE_LAT(P), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .flush(flush), .reg_AB_en(reg_AB_en), .in_sel(in_sel),
    .iter_start(iter_start), .iter_done(iter_done), .iter_abort(iter_abort),
    .res_en(res_en), .res_valid(res_valid), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit err;} ev_t;

  int       cyc = 0;
  bit       run = 1'b0;
  int       n_checks = 0;
  int       n_fail = 0;
  ev_t      rv_q[$];
  bit [5:0] exp_m[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic setb(input int cy, input int b);
    bit [5:0] v;
    v = exp_m.exists(cy) ? exp_m[cy] : 6'd0;
    v[b] = 1'b1;
    exp_m[cy] = v;
  endtask

  // 0 = single pass, 1 = two passes, 2 = iterative unit.
  function automatic int cls_of(input logic [4:0] op);
    if (op == 5'd4 || op == 5'd11) return 2;
    if (op == 5'd2 || op == 5'd3) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      bit [5:0] e;
      ev_t      ev;
      e = exp_m.exists(cyc) ? exp_m[cyc] : 6'd0;
      chk("strobes", 32'({busy, ~in_sel, res_en, iter_abort, iter_start, reg_AB_en}), 32'(e));
      chk("req_ready", 32'(req_ready), 32'(!e[BBusy] && !flush));
      while (rv_q.size() > 0 && rv_q[0].cyc < cyc) begin
        ev = rv_q.pop_front();
        chk("res_valid missing", 32'(cyc), 32'(ev.cyc));
      end
      if (res_valid) begin
        if (rv_q.size() == 0) begin
          chk("res_valid unexpected", 32'(1), 32'(0));
        end else begin
          ev = rv_q.pop_front();
          chk("res_valid cycle", 32'(cyc), 32'(ev.cyc));
          chk("res_err", 32'(res_err), 32'(ev.err));
        end
      end else begin
        chk("res_err idle", 32'(res_err), 32'(0));
      end
    end
  end

  // One idle cycle; req_valid is only raised together with flush so nothing is accepted.
  task automatic idle_cycle(input bit rv_flush);
    @(posedge clk); #1;
    req_valid = rv_flush;
    flush     = rv_flush;
    req_op    = 5'($urandom);
    iter_done = 1'($urandom_range(0, 1));
  endtask

  // d: cycles from accept to iter_done (>T means never); frel: 0 none, -1 random, else flush offset.
  task automatic issue(input logic [4:0] op, input int d, input int frel);
    int c, res, last, f, cl;
    bit fl, err, fl_early;
    repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    c = cyc;
    req_valid = 1'b1;
    req_op    = op;
    flush     = 1'b0;
    iter_done = 1'($urandom_range(0, 1));
    cl  = cls_of(op);
    err = (cl == 2) && (d > T);
    if (cl == 0)      res = c + P + 1;
    else if (cl == 1) res = c + 2 * P + 1;
    else              res = (d <= T) ? c + d + 1 : c + T + 1;
    fl = (frel != 0);
    if (frel < 0) f = c + int'($urandom_range(1, res - c));
    else          f = c + frel;
    last = fl ? f : res;
    fl_early = fl && (f < res);
    setb(c, BAben);
    for (int i = c + 1; i <= last; i++) setb(i, BBusy);
    if (cl == 1) for (int i = c + P + 1; i <= c + 2 * P && i <= last; i++) setb(i, BNinS);
    if (cl == 2) begin
      if (!(fl && f == c + 1)) setb(c + 1, BStart);
      if (fl_early) setb(f, BAbort);
      else if (err) setb(c + T, BAbort);
    end
    if (!fl_early && !err) setb(res - 1, BResEn);
    if (!fl) rv_q.push_back('{cyc: res, err: err});
    for (int i = c + 1; i <= last; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 5'($urandom);
      flush     = fl && (cyc == f);
      iter_done = (cl == 2) ? (cyc == c + d) : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic rand_op(output logic [4:0] op, output int d);
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 0)      op = 5'b00100;
    else if (r == 1) op = 5'b01011;
    else if (r == 2) op = {4'b0001, 1'($urandom_range(0, 1))};
    else             op = 5'($urandom);
    r = int'($urandom_range(0, 3));
    if (r == 0)      d = T + 10;
    else if (r == 1) d = T;
    else             d = int'($urandom_range(1, 20));
  endtask

  initial begin
    logic [4:0] op;
    int         d;
    // Reset values, with and without flush.
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset in_sel", 32'(in_sel), 32'(1));
    chk("reset req_ready", 32'(req_ready), 32'(1));
    chk("reset res_valid", 32'(res_valid), 32'(0));
    chk("reset iter_start", 32'(iter_start), 32'(0));
    flush = 1'b1;
    #1 chk("reset flush req_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0;
    run = 1'b1;

    idle_cycle(1'b1);
    issue(5'b00000, 0, 0);
    issue(5'b00011, 0, 0);
    issue(5'b00100, 10, 0);
    issue(5'b01011, T + 10, 0);
    issue(5'b00100, 20, 5);
    issue(5'b00100, T, 0);
    issue(5'b00010, 0, 5);
    for (int k = 0; k < 40; k++) begin
      rand_op(op, d);
      issue(op, d, ($urandom_range(0, 4) == 0) ? -1 : 0);
    end

    // Reset while in the second pass of a fused op.
    idle_cycle(1'b0);
    run = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 5'b00011; flush = 1'b0; iter_done = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (P + 1) @(posedge clk);
    #1 chk("pass2 in_sel", 32'(in_sel), 32'(0));
    chk("pass2 busy", 32'(busy), 32'(1));
    reset = 1'b1;
    #1 chk("mid reset busy", 32'(busy), 32'(0));
    chk("mid reset in_sel", 32'(in_sel), 32'(1));
    chk("mid reset iter_abort", 32'(iter_abort), 32'(0));
    chk("mid reset res_en", 32'(res_en), 32'(0));
    chk("mid reset req_ready", 32'(req_ready), 32'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    run = 1'b1;
    issue(5'b00000, 0, 0);

    repeat (4) idle_cycle(1'b0);
    chk("scoreboard drained", 32'(rv_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
